// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the byte-serial memory controller and for the control
// unit that generates mem_size:
//   - mem_state_e   : controller FSM states
//   - SIZE_*        : one-hot mem_size encodings {LB, LBU, LH, LHU}, 0 = word
//   - byte_count    : number of SRAM byte cycles (N) for a size code
//   - last_index    : index of the final byte cycle (N-1)
//   - is_misaligned : natural-alignment test used by the optional trap
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD        = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_STROBE = 3'd3,
        ST_DONE      = 3'd4
    } mem_state_e;

    localparam logic [3:0] SIZE_WORD = 4'b0000;
    localparam logic [3:0] SIZE_LB   = 4'b1000;
    localparam logic [3:0] SIZE_LBU  = 4'b0100;
    localparam logic [3:0] SIZE_LH   = 4'b0010;
    localparam logic [3:0] SIZE_LHU  = 4'b0001;

    // Byte lanes touched by an access; any byte bit wins over halfword bits.
    function automatic logic [2:0] byte_count(input logic [3:0] size);
        logic [2:0] n;
        if (size[3] | size[2]) begin
            n = 3'd1;
        end else if (size[1] | size[0]) begin
            n = 3'd2;
        end else begin
            n = 3'd4;
        end
        return n;
    endfunction

    // Final byte index (N-1) kept as a 2-bit value for the byte counter.
    function automatic logic [1:0] last_index(input logic [3:0] size);
        logic [1:0] idx;
        case (byte_count(size))
            3'd1:    idx = 2'd0;
            3'd2:    idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [3:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (byte_count(size))
            3'd2:    mis = addr_lo[0];
            3'd4:    mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_extend.sv
// -----------------------------------------------------------------------------
// mem_extend
// Combinational load-result extension.
// Ports:
//   data_i [31:0] : bytes assembled little-endian from the SRAM
//   size_i [3:0]  : one-hot size {LB, LBU, LH, LHU}, 0 = word
//   ext_o  [31:0] : sign/zero-extended value to drive onto the shared bus
// -----------------------------------------------------------------------------
module mem_extend
    import mem_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [3:0]  size_i,
    output logic [31:0] ext_o
);

    // Select sign or zero extension from the access size.
    always_comb begin
        ext_o = data_i;
        case (size_i)
            SIZE_LB:  ext_o = {{24{data_i[7]}}, data_i[7:0]};
            SIZE_LBU: ext_o = {24'h00_0000, data_i[7:0]};
            SIZE_LH:  ext_o = {{16{data_i[15]}}, data_i[15:0]};
            SIZE_LHU: ext_o = {16'h0000, data_i[15:0]};
            default:  ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_serial_ctrl.sv
// -----------------------------------------------------------------------------
// mem_serial_ctrl
// Byte-serial controller between the microcoded control unit and an 8-bit
// asynchronous SRAM. Word/halfword accesses become little-endian byte cycles;
// loads are extended (mem_extend) and driven onto the shared bus in DONE.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword /
// word accesses (no SRAM cycles, mem_fault pulse in DONE, load returns 0).
// Without it misaligned accesses run at consecutive byte addresses and the
// mem_fault port does not exist.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   addr [31:0]     : byte address (low SRAM_AW bits used, wraps)
//   bus  [31:0]     : shared data bus (store data in, load data out in DONE)
//   mem_read/write  : request strobes (both high = store)
//   mem_size [3:0]  : one-hot {LB, LBU, LH, LHU}, 0 = word
//   mem_busy        : stall to the control unit (combinational)
//   mem_fault       : misalignment pulse (MEM_MISALIGN_TRAP_EN only)
//   sram_addr       : SRAM byte address
//   sram_data [7:0] : SRAM data, driven only in the write states
//   sram_oe_n/we_n  : SRAM output/write enables, active low
// -----------------------------------------------------------------------------
module mem_serial_ctrl
    import mem_pkg::*;
#(
    parameter int SRAM_AW = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    inout  wire  [31:0]        bus,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [3:0]         mem_size,
    output logic               mem_busy,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic               mem_fault,
`endif
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [7:0]         sram_data,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    mem_state_e         state_q, state_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [3:0]         size_q, size_d;
    logic               wr_q, wr_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        data_q, data_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic               fault_q, fault_d;
`endif

    logic               req_s;
    logic [31:0]        ext_s;
    logic [7:0]         wr_byte_s;
    logic               unused_addr_s;

    assign req_s         = mem_read | mem_write;
    // Upper address bits beyond the SRAM are deliberately ignored.
    assign unused_addr_s = ^addr;

    mem_extend u_extend (
        .data_i (data_q),
        .size_i (size_q),
        .ext_o  (ext_s)
    );

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wr_d    = wr_q;
        last_d  = last_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef MEM_MISALIGN_TRAP_EN
        fault_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    addr_d  = addr[SRAM_AW-1:0];
                    size_d  = mem_size;
                    wr_d    = mem_write;
                    last_d  = last_index(mem_size);
                    idx_d   = 2'd0;
                    data_d  = mem_write ? bus : 32'h0000_0000;
                    state_d = mem_write ? ST_WR_SETUP : ST_RD;
`ifdef MEM_MISALIGN_TRAP_EN
                    // Trapped access skips the SRAM entirely; load result is 0.
                    if (is_misaligned(mem_size, addr[1:0])) begin
                        state_d = ST_DONE;
                        data_d  = 32'h0000_0000;
                        fault_d = 1'b1;
                    end else begin
                        fault_d = 1'b0;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                data_d[{idx_q, 3'b000} +: 8] = sram_data;
                if (idx_q == last_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_RD;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                if (idx_q == last_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_WR_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SRAM pins are registered, so they are computed from the next state.
        sram_addr_d = addr_d + SRAM_AW'(idx_d);
        oe_n_d      = (state_d == ST_RD)        ? 1'b0 : 1'b1;
        we_n_d      = (state_d == ST_WR_STROBE) ? 1'b0 : 1'b1;
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= 4'b0000;
            wr_q        <= 1'b0;
            last_q      <= 2'd0;
            idx_q       <= 2'd0;
            data_q      <= 32'h0000_0000;
            sram_addr_q <= '0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wr_q        <= wr_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            sram_addr_q <= sram_addr_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
`ifdef MEM_MISALIGN_TRAP_EN
            fault_q     <= fault_d;
`endif
        end
    end

    // Byte lane presented to the SRAM during a write cycle.
    always_comb begin
        wr_byte_s = data_q[{idx_q, 3'b000} +: 8];
    end

    // Reset gates the strobes and drivers so an aborted access stops at once.
    assign sram_addr = sram_addr_q;
    assign sram_oe_n = oe_n_q | reset;
    assign sram_we_n = we_n_q | reset;
    assign mem_busy  = ~reset & ((state_q == ST_IDLE & req_s) |
                                 (state_q == ST_RD) |
                                 (state_q == ST_WR_SETUP) |
                                 (state_q == ST_WR_STROBE));
    assign sram_data = (~reset & ((state_q == ST_WR_SETUP) | (state_q == ST_WR_STROBE)))
                       ? wr_byte_s : 8'bzzzz_zzzz;
    assign bus       = (~reset & (state_q == ST_DONE) & ~wr_q)
                       ? ext_s : 32'hzzzz_zzzz;
`ifdef MEM_MISALIGN_TRAP_EN
    assign mem_fault = fault_q;
`endif

endmodule

// File: tb/tb_mem_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_serial_ctrl
// Directed stimulus against mem_serial_ctrl with an 8-bit SRAM model. Each
// access pushes its expected completion into a scoreboard; a monitor pops on
// every busy-falling (DONE) cycle and checks the load value on bus. A second
// scoreboard checks every SRAM write (address, data, setup cycle).
// -----------------------------------------------------------------------------
module tb_mem_serial_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_size;
    logic        mem_busy;
    logic [15:0] sram_addr;
    logic        sram_oe_n;
    logic        sram_we_n;
    wire  [31:0] bus_w;
    wire  [7:0]  sram_data_w;
    logic [31:0] tb_bus;
    logic        tb_drv;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mem_fault;
`endif

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;
    int we_cnt = 0;
    int fault_cnt = 0;

    // Completion scoreboard: is_load flag and expected bus value.
    bit          exp_ld_q [$];
    logic [31:0] exp_val_q [$];
    // SRAM write scoreboard.
    logic [15:0] wexp_a_q [$];
    logic [7:0]  wexp_d_q [$];

    always #5 clk = ~clk;

    assign bus_w       = tb_drv ? tb_bus : 32'hzzzz_zzzz;
    assign sram_data_w = (!sram_oe_n) ? mem[sram_addr] : 8'bzzzz_zzzz;

    mem_serial_ctrl #(.SRAM_AW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .bus       (bus_w),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_size  (mem_size),
        .mem_busy  (mem_busy),
`ifdef MEM_MISALIGN_TRAP_EN
        .mem_fault (mem_fault),
`endif
        .sram_addr (sram_addr),
        .sram_data (sram_data_w),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SRAM write model plus write scoreboard and setup-cycle check.
    logic [15:0] prev_addr = 16'h0000;
    logic        prev_we_n = 1'b1;
    always @(posedge clk) begin
        if (!sram_we_n) begin
            we_cnt++;
            chk("we_setup_addr", {16'h0000, sram_addr}, {16'h0000, prev_addr});
            chk("we_setup_high", {31'd0, prev_we_n}, 32'd1);
            if (wexp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected none", sram_addr, sram_data_w);
            end else begin
                chk("write_addr", {16'h0000, sram_addr}, {16'h0000, wexp_a_q.pop_front()});
                chk("write_data", {24'h000000, sram_data_w}, {24'h000000, wexp_d_q.pop_front()});
            end
            mem[sram_addr] = sram_data_w;
        end
        prev_addr = sram_addr;
        prev_we_n = sram_we_n;
    end

    // Completion monitor: pops one entry per busy fall, checks load data.
    bit prev_busy = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (!sram_oe_n) oe_cnt++;
`ifdef MEM_MISALIGN_TRAP_EN
                if (mem_fault) fault_cnt++;
`endif
                if (prev_busy && !mem_busy) begin
                    if (exp_ld_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got completion, expected none");
                    end else begin
                        if (exp_ld_q.pop_front()) begin
                            chk("load_bus", bus_w, exp_val_q.pop_front());
                        end else begin
                            void'(exp_val_q.pop_front());
                        end
                    end
                end
                prev_busy = mem_busy;
            end else begin
                prev_busy = 1'b0;
            end
        end
    end

    // One control-unit access: hold lines while busy, scramble them after acceptance.
    task automatic access(input bit rd, input bit wr, input logic [3:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_busy);
        int nb;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_size = sz; addr = a; tb_bus = wd; tb_drv = wr;
        oe_cnt = 0; we_cnt = 0; fault_cnt = 0;
        nb = 0;
        #2;
        while (mem_busy && nb < 40) begin
            nb++;
            @(negedge clk);
            if (nb == 1) begin
                addr = ~a; tb_bus = ~wd;
                mem_size = (sz == SIZE_WORD) ? SIZE_LB : SIZE_WORD;
            end
            #2;
        end
        chk("busy_cycles", 32'(nb), 32'(exp_busy));
        mem_read = 1'b0; mem_write = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic push_load(input logic [31:0] v);
        exp_ld_q.push_back(1'b1); exp_val_q.push_back(v);
    endtask

    task automatic push_store();
        exp_ld_q.push_back(1'b0); exp_val_q.push_back(32'h0000_0000);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wexp_a_q.push_back(a); wexp_d_q.push_back(d);
    endtask

    initial begin
        for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 4'b0000;
        addr = 32'h0000_0000; tb_bus = 32'h0000_0000; tb_drv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state, with a request pending during reset.
        chk("rst_busy", {31'd0, mem_busy}, 32'd0);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_sram_addr", {16'h0000, sram_addr}, 32'h0000_0000);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("rst_fault", {31'd0, mem_fault}, 32'd0);
`endif
        mem_read = 1'b0; reset = 1'b0;
        repeat (2) @(posedge clk);

        // Word load at 0x10.
        mem[16'h0010] = 8'h78; mem[16'h0011] = 8'h56; mem[16'h0012] = 8'h34; mem[16'h0013] = 8'h12;
        push_load(32'h1234_5678);
        access(1'b1, 1'b0, SIZE_WORD, 32'h0000_0010, 32'h0, 5);
        chk("word_oe_cycles", 32'(oe_cnt), 32'd4);

        // Byte loads, signed and unsigned.
        mem[16'h0011] = 8'h80;
        push_load(32'hFFFF_FF80);
        access(1'b1, 1'b0, SIZE_LB, 32'h0000_0011, 32'h0, 2);
        push_load(32'h0000_0080);
        access(1'b1, 1'b0, SIZE_LBU, 32'h0000_0011, 32'h0, 2);

        // Word store then read back.
        push_wr(16'h0020, 8'hEF); push_wr(16'h0021, 8'hBE);
        push_wr(16'h0022, 8'hAD); push_wr(16'h0023, 8'hDE);
        push_store();
        access(1'b0, 1'b1, SIZE_WORD, 32'h0000_0020, 32'hDEAD_BEEF, 9);
        chk("store_we_pulses", 32'(we_cnt), 32'd4);
        chk("store_oe_cycles", 32'(oe_cnt), 32'd0);
        push_load(32'hDEAD_BEEF);
        access(1'b1, 1'b0, SIZE_WORD, 32'h0000_0020, 32'h0, 5);

        // Halfword load at an odd address.
        mem[16'h0101] = 8'h34; mem[16'h0102] = 8'hF2;
`ifdef MEM_MISALIGN_TRAP_EN
        push_load(32'h0000_0000);
        access(1'b1, 1'b0, SIZE_LH, 32'h0000_0101, 32'h0, 1);
        chk("mis_fault_pulses", 32'(fault_cnt), 32'd1);
        chk("mis_oe_cycles", 32'(oe_cnt), 32'd0);
`else
        push_load(32'hFFFF_F234);
        access(1'b1, 1'b0, SIZE_LH, 32'h0000_0101, 32'h0, 3);
        chk("mis_oe_cycles", 32'(oe_cnt), 32'd2);
`endif

        // Word store wrapping past the top of the SRAM.
        push_store();
`ifdef MEM_MISALIGN_TRAP_EN
        access(1'b0, 1'b1, SIZE_WORD, 32'h0000_FFFF, 32'h0403_0201, 1);
        chk("wrap_we_pulses", 32'(we_cnt), 32'd0);
`else
        push_wr(16'hFFFF, 8'h01); push_wr(16'h0000, 8'h02);
        push_wr(16'h0001, 8'h03); push_wr(16'h0002, 8'h04);
        access(1'b0, 1'b1, SIZE_WORD, 32'h0000_FFFF, 32'h0403_0201, 9);
        chk("wrap_we_pulses", 32'(we_cnt), 32'd4);
`endif

        // Halfword store, then unsigned and signed halfword loads.
        push_wr(16'h0030, 8'h34); push_wr(16'h0031, 8'h92);
        push_store();
        access(1'b0, 1'b1, SIZE_LH, 32'hA5A5_0030, 32'hA5A5_9234, 5);
        push_load(32'h0000_9234);
        access(1'b1, 1'b0, SIZE_LHU, 32'h0000_0030, 32'h0, 3);
        push_load(32'hFFFF_9234);
        access(1'b1, 1'b0, SIZE_LH, 32'h0000_0030, 32'h0, 3);

        // Read and write together behave as a store.
        push_wr(16'h0050, 8'h77);
        push_store();
        access(1'b1, 1'b1, SIZE_LB, 32'h0000_0050, 32'h1122_3377, 3);
        chk("rw_mem", {24'h000000, mem[16'h0050]}, 32'h0000_0077);

        // Reset during the second write strobe of a word store.
        mem[16'h0041] = 8'h55;
        push_wr(16'h0040, 8'hDD);
        @(negedge clk);
        mem_write = 1'b1; mem_size = SIZE_WORD; addr = 32'h0000_0040;
        tb_bus = 32'hAABB_CCDD; tb_drv = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1; mem_write = 1'b0; tb_drv = 1'b0;
        @(negedge clk);
        chk("abort_busy_in_reset", {31'd0, mem_busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("abort_busy_idle", {31'd0, mem_busy}, 32'd0);
        chk("abort_byte0", {24'h000000, mem[16'h0040]}, 32'h0000_00DD);
        chk("abort_byte1", {24'h000000, mem[16'h0041]}, 32'h0000_0055);
        push_load(32'hFFFF_FFDD);
        access(1'b1, 1'b0, SIZE_LB, 32'h0000_0040, 32'h0, 2);

        repeat (3) @(posedge clk);
        chk("done_queue_empty", 32'(exp_ld_q.size()), 32'd0);
        chk("write_queue_empty", 32'(wexp_a_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
